cic_decim_serial: RTL and testbench
===================================

// Module: cic_decim_serial
// PURPOSE
//  Parametrised successor of the fixed 3rd-order /64 CIC decimator for 1-bit delta-sigma bitstreams.
//  Single clock with input-valid qualification: no divided clocks.
//  Order is parametrised; decimation ratio 2^dec_log2 is selectable at run time.
//  Output is gain-normalised to a constant full scale.
//  Words go out both in parallel and as a valid/ready MSB-first byte stream, replacing the free-running output mux.
// PARAMETERS
//  ORDER          3   number of integrator and comb stages (N), >=1
//  RATE_LOG2_MAX  6   maximum log2 decimation ratio; BW = ORDER*RATE_LOG2_MAX+1
//  NBYTES         derived: ceil(BW/8); default 3 (BW=19)
// PORTS
//  clk        in   1     system clock, all logic rising-edge
//  rst        in   1     synchronous reset, active high
//  in_valid   in   1     in_bit is a modulator sample this cycle
//  in_bit     in   1     DSM bit; 1 -> +1, 0 -> 0 (unsigned count)
//  dec_log2   in   DW    requested log2 ratio, DW=$clog2(RATE_LOG2_MAX+1)
//  ovr_clr    in   1     clears sticky overrun
//  out_data   out  BW    normalised decimated word, unsigned
//  out_valid  out  1     one-cycle strobe, out_data new
//  settling   out  1     high while post-reset/post-rate-change outputs are suppressed
//  byte_data  out  8     serial byte, MSB byte of zero-extended word first
//  byte_valid out  1     byte_data valid
//  byte_ready in   1     sink accepts byte when byte_valid&byte_ready
//  byte_last  out  1     current byte is last of word
//  overrun    out  1     sticky: a word arrived while serializer busy and was dropped
// BEHAVIOUR
//  Reset (rst=1 at edge): integrators, combs, counter, out_data, out_valid, byte_*, overrun = 0.
//   Active rate R_log2 = RATE_LOG2_MAX; settle_cnt = ORDER; serializer IDLE.
//  Integrators: BW-bit modulo-2^BW, update only when in_valid; wrap is intended (Hogenauer).
//  Decimation counter counts accepted samples 0..2^R_log2-1.
//   On the edge accepting sample 2^R_log2 it wraps to 0 and sets tick (registered).
//  Comb stage: on the edge where tick=1, last integrator value passes ORDER differencers (delays of 1 decimated sample).
//   Result is shifted left by ORDER*(RATE_LOG2_MAX-R_log2) and registered into out_data.
//  Latency: out_valid is high the cycle after that edge, i.e. 2 edges after the R-th sample's accept edge.
//   out_valid is 1 cycle wide; out_data holds until the next word.
//  Full scale: all-ones input -> 2^(ORDER*RATE_LOG2_MAX) for every legal ratio.
//  Suppression: while settle_cnt!=0, each tick decrements settle_cnt, no out_valid, settling=1.
//  Rate change: dec_log2 is sampled only at a tick.
//   Values 0 or >RATE_LOG2_MAX are clamped to RATE_LOG2_MAX.
//   If the clamped value differs from R_log2: load new R_log2, clear integrators/combs/counter, settle_cnt=ORDER, no out_valid that tick.
//  Serializer FSM: IDLE -> SEND on out_valid (latch word, idx=0).
//   In SEND: byte_valid=1; byte_data = byte (NBYTES-1-idx); byte_last = (idx==NBYTES-1).
//   A handshake advances idx; handshake on last byte -> IDLE.
//   Simultaneous out_valid and last-byte handshake: load new word, stay SEND, idx=0, no overrun.
//   out_valid in SEND otherwise: new word dropped, overrun=1; held word is untouched.
//   byte_data/byte_last are stable while byte_valid&!byte_ready.
//  overrun clears on ovr_clr; if ovr_clr and a new drop occur in the same cycle, the set wins.
//  Reset mid-word: byte_valid=0 the following cycle; the partial word is discarded.
// TESTING
//  1 rst, dec_log2=6, in_valid=1, in_bit=1 constant -> 3 suppressed ticks.
//    Then out_data=0x40000 every 64 samples; bytes 0x04,0x00,0x00 with byte_last on the 3rd.
//  2 Alternating 1,0 input, R=64 -> settled out_data=0x20000. All-zero input -> 0x00000.
//  3 dec_log2=4, all ones -> 3 suppressed ticks, then out_data=0x40000 every 16 samples (4096<<6).
//    Switch to 6 -> 3 suppressed ticks, then every 64 samples.
//  4 in_valid toggling 1/0 each cycle -> output rate halves in clk terms; values identical to test 1.
//  5 byte_ready=0 for 200 cycles at R=16 -> overrun=1; held bytes stay 0x04,0x00,0x00.
//    ready=1 -> held word drains unchanged; ovr_clr -> overrun=0.
//  6 Last-byte handshake coincident with out_valid -> next word starts next cycle, overrun stays 0.
//    rst during SEND -> byte_valid=0 next cycle.

Source files
------------

// File: rtl/cic_decim_serial.sv
// CIC decimator for 1-bit delta-sigma streams: run-time ratio, gain-normalised output,
// parallel word plus valid/ready MSB-first byte stream.
module cic_decim_serial #(
  parameter  int ORDER         = 3,
  parameter  int RATE_LOG2_MAX = 6,
  localparam int BW            = ORDER * RATE_LOG2_MAX + 1,
  localparam int DW            = $clog2(RATE_LOG2_MAX + 1),
  localparam int NBYTES        = (BW + 7) / 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_bit,
  input  logic [DW-1:0] dec_log2,
  input  logic          ovr_clr,
  output logic [BW-1:0] out_data,
  output logic          out_valid,
  output logic          settling,
  output logic [7:0]    byte_data,
  output logic          byte_valid,
  input  logic          byte_ready,
  output logic          byte_last,
  output logic          overrun
);

  localparam int WW  = NBYTES * 8;
  localparam int IW  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int SCW = $clog2(ORDER + 1);
  localparam int CW  = RATE_LOG2_MAX;

  localparam logic [DW-1:0]  RATE_MAX    = DW'(RATE_LOG2_MAX);
  localparam logic [SCW-1:0] SETTLE_INIT = SCW'(ORDER);
  localparam logic [IW-1:0]  IDX_LAST    = IW'(NBYTES - 1);
  localparam logic [0:0]     ST_IDLE     = 1'b0;
  localparam logic [0:0]     ST_SEND     = 1'b1;

  // Left shift that restores full scale 2^(ORDER*RATE_LOG2_MAX) at lower ratios.
  function automatic int shift_amt(input logic [DW-1:0] r);
    return ORDER * (RATE_LOG2_MAX - int'(r));
  endfunction

  logic [BW-1:0]  integ_q [ORDER];
  logic [BW-1:0]  integ_d [ORDER];
  logic [BW-1:0]  dly_q   [ORDER];
  logic [BW-1:0]  dly_d   [ORDER];
  logic [BW-1:0]  comb_s  [ORDER+1];
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW:0]    cnt_lim_s;
  logic           tick_q, tick_d;
  logic [DW-1:0]  rate_q, rate_d, rate_req_s;
  logic           rate_chg_s;
  logic [SCW-1:0] settle_q, settle_d;
  logic [BW-1:0]  out_data_q, out_data_d;
  logic           out_valid_q, out_valid_d;
  logic           settling_q, settling_d;

  logic [0:0]     state_q, state_d;
  logic [WW-1:0]  sh_q, sh_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           last_q, last_d;
  logic           overrun_q, overrun_d;
  logic           hs_s, load_s, drop_s;

  // Integrators, decimation counter, comb differencers, settling and rate control.
  always_comb begin
    rate_req_s = ((dec_log2 == {DW{1'b0}}) || (dec_log2 > RATE_MAX)) ? RATE_MAX : dec_log2;
    rate_chg_s = tick_q && (rate_req_s != rate_q);
    cnt_lim_s  = ({{CW{1'b0}}, 1'b1} << rate_q) - {{CW{1'b0}}, 1'b1};
    comb_s[0]  = integ_q[ORDER-1];
    for (int k = 0; k < ORDER; k++) begin
      comb_s[k+1] = comb_s[k] - dly_q[k];
    end
    integ_d     = integ_q;
    dly_d       = dly_q;
    cnt_d       = cnt_q;
    tick_d      = 1'b0;
    rate_d      = rate_q;
    settle_d    = settle_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    if (rate_chg_s) begin
      // New ratio: restart the filter from zero state and suppress until it settles.
      rate_d   = rate_req_s;
      settle_d = SETTLE_INIT;
      cnt_d    = {CW{1'b0}};
      for (int k = 0; k < ORDER; k++) begin
        integ_d[k] = {BW{1'b0}};
        dly_d[k]   = {BW{1'b0}};
      end
    end else begin
      if (in_valid) begin
        integ_d[0] = integ_q[0] + {{(BW-1){1'b0}}, in_bit};
        for (int k = 1; k < ORDER; k++) begin
          integ_d[k] = integ_q[k] + integ_d[k-1];
        end
        if (cnt_q == cnt_lim_s[CW-1:0]) begin
          cnt_d  = {CW{1'b0}};
          tick_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_q;
      end
      if (tick_q) begin
        for (int k = 0; k < ORDER; k++) begin
          dly_d[k] = comb_s[k];
        end
        if (settle_q != {SCW{1'b0}}) begin
          settle_d = settle_q - 1'b1;
        end else begin
          out_valid_d = 1'b1;
          out_data_d  = comb_s[ORDER] << shift_amt(rate_q);
        end
      end else begin
        settle_d = settle_q;
      end
    end
    settling_d = (settle_d != {SCW{1'b0}});
  end

  // Byte serializer: a word landing on the last-byte handshake is loaded, otherwise dropped.
  always_comb begin
    hs_s    = (state_q == ST_SEND) && byte_ready;
    load_s  = out_valid_q && ((state_q == ST_IDLE) || (hs_s && last_q));
    drop_s  = out_valid_q && !load_s;
    state_d = state_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    last_d  = last_q;
    if (load_s) begin
      state_d         = ST_SEND;
      sh_d            = {WW{1'b0}};
      sh_d[BW-1:0]    = out_data_q;
      idx_d           = {IW{1'b0}};
      last_d          = (IDX_LAST == {IW{1'b0}});
    end else if (hs_s) begin
      if (last_q) begin
        state_d = ST_IDLE;
        last_d  = 1'b0;
      end else begin
        sh_d   = sh_q << 4'd8;
        idx_d  = idx_q + 1'b1;
        last_d = ((idx_q + 1'b1) == IDX_LAST);
      end
    end else begin
      state_d = state_q;
    end
    if (drop_s) begin
      overrun_d = 1'b1;
    end else if (ovr_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < ORDER; k++) begin
        integ_q[k] <= {BW{1'b0}};
        dly_q[k]   <= {BW{1'b0}};
      end
      cnt_q       <= {CW{1'b0}};
      tick_q      <= 1'b0;
      rate_q      <= RATE_MAX;
      settle_q    <= SETTLE_INIT;
      settling_q  <= 1'b1;
      out_data_q  <= {BW{1'b0}};
      out_valid_q <= 1'b0;
      state_q     <= ST_IDLE;
      sh_q        <= {WW{1'b0}};
      idx_q       <= {IW{1'b0}};
      last_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      integ_q     <= integ_d;
      dly_q       <= dly_d;
      cnt_q       <= cnt_d;
      tick_q      <= tick_d;
      rate_q      <= rate_d;
      settle_q    <= settle_d;
      settling_q  <= settling_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      state_q     <= state_d;
      sh_q        <= sh_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign settling   = settling_q;
  assign byte_data  = sh_q[WW-1 -: 8];
  assign byte_valid = (state_q == ST_SEND);
  assign byte_last  = last_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_cic_decim_serial.sv
// Self-checking bench for cic_decim_serial: convolution reference model feeding a word
// scoreboard, plus a byte-stream model checked every cycle.
module tb_cic_decim_serial;
  localparam int ORD  = 3;
  localparam int RMAX = 6;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_bit, ovr_clr, byte_ready;
  logic [2:0]  dec_log2;
  logic [18:0] out_data;
  logic        out_valid, settling, byte_valid, byte_last, overrun;
  logic [7:0]  byte_data;

  cic_decim_serial dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .dec_log2(dec_log2),
    .ovr_clr(ovr_clr), .out_data(out_data), .out_valid(out_valid), .settling(settling),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .byte_last(byte_last), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct { logic [18:0] w; time t; } exp_t;
  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;
  logic mon_en = 1'b0;

  // CIC model state
  int hist[$];
  int m_rate = RMAX, m_settle = ORD, m_cnt = 0;
  bit m_tick = 1'b0;
  // serializer model state
  bit          m_busy = 1'b0, m_ovr = 1'b0;
  int          m_idx = 0;
  logic [23:0] m_word = 24'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Direct convolution with the (1+z^-1+..+z^-(R-1))^ORD impulse response.
  function automatic logic [18:0] cic_ref();
    int r;
    int h[$];
    int t[$];
    int s;
    longint y;
    r = 1 << m_rate;
    h.push_back(1);
    for (int n = 0; n < ORD; n++) begin
      t.delete();
      for (int i = 0; i < h.size() + r - 1; i++) begin
        s = 0;
        for (int j = 0; j < r; j++)
          if (i - j >= 0 && i - j < h.size()) s += h[i-j];
        t.push_back(s);
      end
      h = t;
    end
    y = 0;
    for (int j = 0; j < h.size() && j < hist.size(); j++)
      y += longint'(h[j]) * longint'(hist[hist.size()-1-j]);
    return 19'(y << (ORD * (RMAX - m_rate)));
  endfunction

  task automatic model_edge(input logic v, input logic b);
    int req;
    bit tk;
    if (rst) begin
      m_rate = RMAX; m_settle = ORD; m_cnt = 0; m_tick = 1'b0; hist.delete();
      return;
    end
    tk = m_tick;
    m_tick = 1'b0;
    if (tk) begin
      req = (dec_log2 == 3'd0 || int'(dec_log2) > RMAX) ? RMAX : int'(dec_log2);
      if (req != m_rate) begin
        m_rate = req; m_settle = ORD; m_cnt = 0; hist.delete();
        return;
      end
      if (m_settle > 0) m_settle--;
      else expq.push_back('{w: cic_ref(), t: $time});
    end
    if (v) begin
      hist.push_back(b ? 1 : 0);
      if (hist.size() > 256) void'(hist.pop_front());
      m_cnt++;
      if (m_cnt == (1 << m_rate)) begin
        m_cnt = 0;
        m_tick = 1'b1;
      end
    end
  endtask

  task automatic step(input logic v, input logic b);
    in_valid = v;
    in_bit   = b;
    @(posedge clk);
    model_edge(v, b);
    #1;
    if (mon_en) chk("settling", settling, (m_settle != 0));
  endtask

  // Output monitor: pops the word scoreboard and tracks the expected byte stream.
  always @(negedge clk) begin
    exp_t e;
    bit got, hs, load;
    logic [23:0] w;
    if (mon_en) begin
      got = 1'b0;
      w   = 24'h0;
      if (expq.size() > 0 && expq[0].t + 5 < $time) begin
        chk("word_late", out_valid, 1'b1);
        void'(expq.pop_front());
      end
      if (out_valid) begin
        chk("spurious_out_valid", out_valid, (expq.size() > 0));
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("out_data", out_data, e.w);
          chk("out_latency", 32'($time - e.t), 32'd5);
          got = 1'b1;
          w   = {5'd0, e.w};
        end
      end
      chk("byte_valid", byte_valid, m_busy);
      if (m_busy) begin
        chk("byte_data", byte_data, m_word[23 - 8*m_idx -: 8]);
        chk("byte_last", byte_last, (m_idx == 2));
      end
      chk("overrun", overrun, m_ovr);
      hs = m_busy && byte_ready;
      if (rst) begin
        m_busy = 1'b0; m_ovr = 1'b0; m_idx = 0;
      end else begin
        load = got && (!m_busy || (hs && m_idx == 2));
        if (load) begin
          m_busy = 1'b1; m_word = w; m_idx = 0;
        end else if (hs) begin
          if (m_idx == 2) m_busy = 1'b0;
          else m_idx++;
        end
        if (got && !load) m_ovr = 1'b1;
        else if (ovr_clr) m_ovr = 1'b0;
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; ovr_clr = 1'b0;
    byte_ready = 1'b1; dec_log2 = 3'd6;
    repeat (3) step(1'b0, 1'b0);
    chk("rst_out_data", out_data, 19'h0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_byte_valid", byte_valid, 1'b0);
    chk("rst_byte_last", byte_last, 1'b0);
    chk("rst_byte_data", byte_data, 8'h00);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_settling", settling, 1'b1);
    rst = 1'b0;
    mon_en = 1'b1;

    // full-scale ones at R=64
    repeat (64 * 6) step(1'b1, 1'b1);
    repeat (2) step(1'b0, 1'b0);
    chk("fs_r64", out_data, 19'h40000);

    // alternating then all-zero input
    for (int i = 0; i < 64 * 4; i++) step(1'b1, (i % 2 == 0));
    repeat (2) step(1'b0, 1'b0);
    chk("half_scale", out_data, 19'h20000);
    repeat (64 * 4) step(1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0);
    chk("zero_scale", out_data, 19'h00000);

    // rate change to 16 and back to 64
    dec_log2 = 3'd4;
    repeat (64 + 16 * 6) step(1'b1, 1'b1);
    repeat (2) step(1'b0, 1'b0);
    chk("fs_r16", out_data, 19'h40000);
    dec_log2 = 3'd6;
    repeat (16 + 64 * 5) step(1'b1, 1'b1);
    repeat (2) step(1'b0, 1'b0);
    chk("fs_r64_again", out_data, 19'h40000);

    // in_valid toggling each cycle
    repeat (64 * 3) begin
      step(1'b1, 1'b1);
      step(1'b0, 1'b0);
    end
    repeat (2) step(1'b0, 1'b0);
    chk("fs_gapped", out_data, 19'h40000);

    // back-pressure at R=16
    dec_log2 = 3'd4;
    repeat (64 + 16 * 5) step(1'b1, 1'b1);
    repeat (6) step(1'b0, 1'b0);
    byte_ready = 1'b0;
    repeat (200) step(1'b1, 1'b1);
    chk("ovr_set", overrun, 1'b1);
    chk("held_valid", byte_valid, 1'b1);
    chk("held_byte0", byte_data, 8'h04);
    chk("held_last", byte_last, 1'b0);
    byte_ready = 1'b1;
    repeat (6) step(1'b0, 1'b0);
    ovr_clr = 1'b1;
    step(1'b0, 1'b0);
    ovr_clr = 1'b0;
    chk("ovr_clr", overrun, 1'b0);

    // R=2 with 2-of-3 valid: each word lands on the previous word's last handshake
    dec_log2 = 3'd1;
    repeat (40) begin
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b0, 1'b0);
    end
    chk("coinc_no_ovr", overrun, 1'b0);
    chk("coinc_streaming", byte_valid, 1'b1);

    // reset in the middle of a word
    byte_ready = 1'b0;
    repeat (2) step(1'b1, 1'b1);
    rst = 1'b1;
    step(1'b0, 1'b0);
    chk("rst_mid_word", byte_valid, 1'b0);
    rst = 1'b0;
    dec_log2 = 3'd6;
    byte_ready = 1'b1;
    repeat (4) step(1'b0, 1'b0);
    chk("scoreboard_empty", expq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
